// File: rtl/johnson_seq_checker_if.sv
// Code-stream bus between a Johnson counter source and its checker.
// The master drives the code under test; the slave returns decode and status.
interface johnson_seq_checker_if #(
    parameter int N     = 3,
    parameter int ERR_W = 8
);
    localparam int IW = $clog2(2 * N);

    logic [N-1:0]     code_in;
    logic             code_valid;
    logic [IW-1:0]    index_out;
    logic             index_valid;
    logic             locked;
    logic             seq_err;
    logic             illegal;
    logic [ERR_W-1:0] err_count;

    modport master (
        output code_in, code_valid,
        input  index_out, index_valid, locked, seq_err, illegal, err_count
    );

    modport slave (
        input  code_in, code_valid,
        output index_out, index_valid, locked, seq_err, illegal, err_count
    );
endinterface

// File: rtl/johnson_seq_checker.sv
// Decodes a Johnson counter code stream to step indices and checks that
// successive codes follow the counting sequence.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   HUNT    | no reference yet; waiting for any legal code
//   ACQUIRE | counting consecutive correct successors toward LOCK_CNT
//   LOCKED  | sequence tracked; a wrong or illegal code drops to HUNT
module johnson_seq_checker #(
    parameter int N        = 3,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    johnson_seq_checker_if.slave  bus
);
    localparam int IW = $clog2(2 * N);
    localparam int MW = 4;

    typedef enum logic [1:0] {HUNT, ACQUIRE, LOCKED} state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    prev_idx_q, prev_idx_d;
    logic [MW-1:0]    match_q, match_d;
    logic [IW-1:0]    index_q, index_d;
    logic             index_valid_q, index_valid_d;
    logic             seq_err_q, seq_err_d;
    logic             illegal_q, illegal_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    int               ones;
    logic             is_low, is_high, code_legal;
    logic [IW-1:0]    code_idx, succ_idx;
    logic [MW-1:0]    match_inc;

    // A legal code is either 0..01..1 or 1..10..0 (with at least one zero).
    always_comb begin
        ones = 0;
        for (int i = 0; i < N; i++) ones = ones + int'(bus.code_in[i]);
        is_low     = (bus.code_in == N'((1 << ones) - 1));
        is_high    = (ones > 0) && (ones < N) &&
                     (bus.code_in == ~N'((1 << (N - ones)) - 1));
        code_legal = is_low || is_high;
        code_idx   = is_low ? IW'(ones) : IW'(2 * N - ones);
    end

    // Explicit wrap keeps 2N-1 -> 0 correct even when 2N is not a power of two.
    assign succ_idx  = (prev_idx_q == IW'(2 * N - 1)) ? '0 : prev_idx_q + IW'(1);
    assign match_inc = match_q + MW'(1);

    always_comb begin
        state_d       = state_q;
        prev_idx_d    = prev_idx_q;
        match_d       = match_q;
        index_d       = index_q;
        index_valid_d = 1'b0;
        seq_err_d     = 1'b0;
        illegal_d     = 1'b0;
        err_count_d   = err_count_q;

        if (bus.code_valid) begin
            if (!code_legal) begin
                illegal_d = 1'b1;
                state_d   = HUNT;
            end else begin
                index_d       = code_idx;
                index_valid_d = 1'b1;
                prev_idx_d    = code_idx;
                case (state_q)
                    HUNT: begin
                        match_d = '0;
                        state_d = ACQUIRE;
                    end
                    ACQUIRE: begin
                        if (code_idx == succ_idx) begin
                            match_d = match_inc;
                            if (match_inc == MW'(LOCK_CNT)) state_d = LOCKED;
                        end else begin
                            match_d = '0;
                        end
                    end
                    LOCKED: begin
                        if (code_idx != succ_idx) begin
                            seq_err_d = 1'b1;
                            state_d   = HUNT;
                        end
                    end
                    default: state_d = HUNT;
                endcase
            end
        end

        if ((seq_err_d || illegal_d) && (err_count_q != '1))
            err_count_d = err_count_q + ERR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= HUNT;
            prev_idx_q    <= '0;
            match_q       <= '0;
            index_q       <= '0;
            index_valid_q <= 1'b0;
            seq_err_q     <= 1'b0;
            illegal_q     <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            prev_idx_q    <= prev_idx_d;
            match_q       <= match_d;
            index_q       <= index_d;
            index_valid_q <= index_valid_d;
            seq_err_q     <= seq_err_d;
            illegal_q     <= illegal_d;
            err_count_q   <= err_count_d;
        end
    end

    assign bus.index_out   = index_q;
    assign bus.index_valid = index_valid_q;
    assign bus.locked      = (state_q == LOCKED);
    assign bus.seq_err     = seq_err_q;
    assign bus.illegal     = illegal_q;
    assign bus.err_count   = err_count_q;
endmodule

// File: tb/tb_johnson_seq_checker.sv
// Randomized plus directed check of johnson_seq_checker against a
// table-driven reference model of the Johnson sequence and lock rules.
module tb_johnson_seq_checker;
    localparam int N        = 3;
    localparam int LOCK_CNT = 3;
    localparam int ERR_W    = 8;
    localparam int IW       = $clog2(2 * N);
    localparam int SEQ_LEN  = 2 * N;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;

    localparam int M_HUNT   = 0;
    localparam int M_ACQ    = 1;
    localparam int M_LOCKED = 2;

    logic clk = 1'b0;
    logic reset;

    johnson_seq_checker_if #(.N(N), .ERR_W(ERR_W)) bus ();

    johnson_seq_checker #(.N(N), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    logic [N-1:0] jc [SEQ_LEN];

    int m_mode, m_prev, m_match, m_index, m_err;
    bit m_ival, m_serr, m_ill;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lookup(input logic [N-1:0] c);
        for (int i = 0; i < SEQ_LEN; i++)
            if (jc[i] == c) return i;
        return -1;
    endfunction

    task automatic model_step(input bit r, input bit v, input logic [N-1:0] c);
        int idx;
        bit correct;
        m_ival = 0; m_serr = 0; m_ill = 0;
        if (r) begin
            m_mode = M_HUNT; m_prev = 0; m_match = 0; m_index = 0; m_err = 0;
            return;
        end
        if (!v) return;
        idx = lookup(c);
        if (idx < 0) begin
            m_ill  = 1;
            m_mode = M_HUNT;
        end else begin
            correct = (idx == (m_prev + 1) % SEQ_LEN);
            m_index = idx;
            m_ival  = 1;
            if (m_mode == M_HUNT) begin
                m_match = 0;
                m_mode  = M_ACQ;
            end else if (m_mode == M_ACQ) begin
                if (correct) begin
                    m_match++;
                    if (m_match == LOCK_CNT) m_mode = M_LOCKED;
                end else begin
                    m_match = 0;
                end
            end else if (!correct) begin
                m_serr = 1;
                m_mode = M_HUNT;
            end
            m_prev = idx;
        end
        if ((m_serr || m_ill) && m_err < ERR_MAX) m_err++;
    endtask

    task automatic step(input bit r, input bit v, input logic [N-1:0] c);
        @(negedge clk);
        reset          = r;
        bus.code_valid = v;
        bus.code_in    = c;
        @(posedge clk);
        model_step(r, v, c);
        #1;
        chk("index_out",   int'(bus.index_out),   m_index);
        chk("index_valid", int'(bus.index_valid), int'(m_ival));
        chk("locked",      int'(bus.locked),      int'(m_mode == M_LOCKED));
        chk("seq_err",     int'(bus.seq_err),     int'(m_serr));
        chk("illegal",     int'(bus.illegal),     int'(m_ill));
        chk("err_count",   int'(bus.err_count),   m_err);
    endtask

    task automatic feed(input logic [N-1:0] c);
        step(0, 1, c);
    endtask

    initial begin
        logic [N-1:0] c;
        int pick;

        jc[0] = '0;
        for (int i = 1; i < SEQ_LEN; i++)
            jc[i] = {jc[i-1][N-2:0], ~jc[i-1][N-1]};

        reset = 1'b1; bus.code_valid = 1'b0; bus.code_in = '0;
        m_mode = M_HUNT; m_prev = 0; m_match = 0; m_index = 0; m_err = 0;
        m_ival = 0; m_serr = 0; m_ill = 0;

        step(1, 0, '0);
        step(1, 1, 3'b011);

        // Full sequence to lock, then wrap 100 -> 000.
        feed(3'b000); feed(3'b001); feed(3'b011);
        chk("locked_before_4th", int'(bus.locked), 0);
        feed(3'b111);
        chk("locked_after_4th", int'(bus.locked), 1);
        feed(3'b110); feed(3'b100); feed(3'b000);
        chk("wrap_index", int'(bus.index_out), 0);
        chk("wrap_locked", int'(bus.locked), 1);

        // Skip 011 -> 110 while locked.
        feed(3'b001); feed(3'b011); feed(3'b110);
        chk("skip_seq_err", int'(bus.seq_err), 1);
        chk("skip_err_count", int'(bus.err_count), 1);

        // Relock, then illegal codes while locked and in HUNT.
        feed(3'b000); feed(3'b001); feed(3'b011); feed(3'b111);
        chk("relock", int'(bus.locked), 1);
        feed(3'b010);
        chk("illegal_hold_index", int'(bus.index_out), 3);
        feed(3'b101);
        chk("illegal_err_count", int'(bus.err_count), 3);

        // Lock with idle gaps interleaved.
        feed(3'b000); step(0, 0, 3'b101); feed(3'b001);
        step(0, 0, 3'b010); step(0, 0, 3'b111); feed(3'b011);
        step(0, 0, 3'b000); feed(3'b111);
        chk("gap_locked", int'(bus.locked), 1);

        // Reset wins over a valid code while locked.
        step(1, 1, 3'b110);
        chk("reset_locked", int'(bus.locked), 0);
        chk("reset_err_count", int'(bus.err_count), 0);

        // Random traffic biased toward the correct successor so lock is reached.
        for (int k = 0; k < 600; k++) begin
            pick = $urandom_range(0, 99);
            if (pick < 60)      c = jc[(m_prev + 1) % SEQ_LEN];
            else if (pick < 75) c = jc[$urandom_range(0, SEQ_LEN - 1)];
            else                c = N'($urandom_range(0, (1 << N) - 1));
            if (pick >= 98)      step(1, 1, c);
            else if (pick >= 90) step(0, 0, c);
            else                 feed(c);
        end

        // Saturation of the error counter.
        step(1, 0, '0);
        for (int k = 0; k < (1 << ERR_W) + 5; k++) feed(3'b010);
        chk("err_saturated", int'(bus.err_count), ERR_MAX);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/johnson_seq_checker.md
Name: johnson_seq_checker

Overview:
- Receive end of the team's sequential-counter path. Monitors the code stream a Johnson-style counter drives, decodes each legal code to its binary step index, and verifies that successive codes follow the counting sequence.
- Reports lock status, sequence errors, illegal codes and a saturating error count.
- Sits downstream of a counter block as a built-in checker or decoder; registered outputs only.

Parameters:
- N, 3, counter width in bits. Sequence length is 2N. Legal range 2..8.
- LOCK_CNT, 3, consecutive correct transitions needed to declare lock (1..15).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- code_in  in  N  counter code under test.
- code_valid  in  1  code_in is sampled this cycle.
- index_out  out  clog2(2N)  decoded step index (0..2N-1) of the last valid legal code.
- index_valid  out  1  one-cycle pulse: index_out updated.
- locked  out  1  level: checker is in LOCKED state.
- seq_err  out  1  one-cycle pulse: legal code but wrong successor while LOCKED.
- illegal  out  1  one-cycle pulse: sampled code is not one of the 2N Johnson codes.
- err_count  out  ERR_W  saturating count of seq_err plus illegal events.

Behaviour:
- Sequence: next = {code[N-2:0], ~code[N-1]}, starting from all-zeros. For N=3: 000(0), 001(1), 011(2), 111(3), 110(4), 100(5), then wraps to 000.
- Legal code test:
  - Code is of the form 0..01..1, index = number of ones, range 0..N.
  - Or of the form 1..10..0 with at least one zero, index = 2N - number of ones.
  - Anything else is illegal. For N=3, 010 and 101 are illegal.
- Reset (reset=1 at posedge) gives: index_out=0, index_valid=0, locked=0, seq_err=0, illegal=0, err_count=0, FSM=HUNT, prev_idx=0, match count=0. Reset wins over code_valid in the same cycle, including mid-acquire or while locked.
- Latency: all outputs are registered and reflect the code sampled on the previous clk edge (1 cycle).
- Cycles with code_valid=0: no state change. index_valid, seq_err and illegal are all 0.
- FSM states HUNT, ACQUIRE, LOCKED. On each valid cycle:
  - HUNT:
    - legal code: store prev_idx, match count=0, go to ACQUIRE.
    - illegal code: stay in HUNT, pulse illegal.
  - ACQUIRE:
    - legal code with idx == (prev_idx+1) mod 2N: match count+1. When it reaches LOCK_CNT, go to LOCKED (locked=1 the next cycle).
    - legal code with wrong successor: restart the acquire with prev_idx=idx and match count=0. No seq_err.
    - illegal code: go to HUNT, pulse illegal.
  - LOCKED:
    - correct successor: stay.
    - wrong legal successor, including a repeated code: pulse seq_err, go to HUNT.
    - illegal code: pulse illegal, go to HUNT.
- Wrap-around: 2N-1 to 0 is a correct successor. The mod-2N arithmetic must not overflow index width.
- index_out and index_valid update on every legal valid code in all states. On an illegal code, index_out holds and index_valid=0.
- err_count increments by 1 per seq_err or illegal event, saturating at 2^ERR_W-1. A single cycle can produce only one event.
- illegal events count in every state. seq_err occurs only in LOCKED.

Test Plan:
- reset, then feed 000,001,011,111,110,100,000 valid every cycle (N=3, LOCK_CNT=3) -> index_out 0,1,2,3,4,5,0 each one cycle later. locked rises 1 cycle after the 4th code (111) is sampled. No errors.
- While locked at index 5 (100), present 000 -> index_out=0, no seq_err, locked stays 1 (wrap-around).
- While locked, present 011 then 110 (skip) -> seq_err pulse on the 110 response cycle, locked=0, err_count=1, FSM back in HUNT.
- Present 010 while locked -> illegal pulse, locked=0, index_out holds, err_count+1. Present 101 in HUNT -> illegal again, err_count+1.
- Gap test: interleave code_valid=0 cycles within a correct sequence -> lock is still achieved, no pulses during idle cycles.
- Assert reset while locked with code_valid=1 -> all outputs return to 0 the next cycle. Force 2^ERR_W+5 illegal codes -> err_count saturates at 255.
